riscv_top: RTL and testbench
============================

RISCV_TOP -- requirements
Module: riscv_top

Interface
REQ-001 Parameter SIM, default 0: 1 selects simulation timing (short baud divisor and debounce).
REQ-002 Parameter CLK_HZ, default 100000000: EXCLK frequency.
REQ-003 Parameter BAUD, default 115200: UART bit rate when SIM=0.
REQ-004 EXCLK  input  1  the single clock; all flops on rising edge.
REQ-005 btnC  input  1  reset, asynchronous, active-low.
REQ-006 btnL  input  1  raw push-button, pause toggle.
REQ-007 btnR  input  1  raw push-button, byte inject.
REQ-008 Rx  input  1  UART receive line, 8N1, idle high.
REQ-009 Tx  output  1  UART transmit line, 8N1, idle high.
REQ-010 led  output  16  status lamps.

Function
REQ-011 The bit period SHALL be DIV = CLK_HZ/BAUD cycles when SIM=0, and 4 cycles when SIM=1.
REQ-012 Rx SHALL pass through a 2-flop synchronizer (reset value 1) before use.
REQ-013 Receiver: on a falling edge it SHALL re-check Rx at DIV/2; high means false start, return to idle.
REQ-014 Receiver SHALL sample 8 data bits LSB-first at DIV intervals from the confirmed start midpoint, then one stop bit.
REQ-015 A byte with stop bit low SHALL be discarded (framing error) without writing the FIFO.
REQ-016 Each good byte SHALL be written to a 16-entry FIFO the cycle after the stop-bit sample and latched into led[7:0].
REQ-017 FIFO full on write: byte dropped, led[15] overflow flag set sticky until reset.
REQ-018 Transmitter SHALL pop the FIFO when idle, not paused, and FIFO non-empty; frame = start 0, 8 data LSB-first, stop 1, each bit DIV cycles.
REQ-019 The first start-bit cycle on Tx SHALL be the cycle after the pop; next pop no earlier than the cycle after the stop bit ends.
REQ-020 Buttons SHALL be debounced: output changes only after the raw input is stable for 2^20 cycles (SIM=0) or 4 cycles (SIM=1).
REQ-021 Debounced btnL rising edge SHALL toggle pause; a frame in progress completes, no new pop while paused; reception continues.
REQ-022 Debounced btnR rising edge SHALL enqueue byte 0x52 (subject to REQ-017).
REQ-023 Receiver write and inject in the same cycle: receiver byte first, inject held pending and written the next cycle.
REQ-024 FIFO simultaneous push and pop SHALL both succeed when non-empty; count unchanged.
REQ-025 led[12:8] = FIFO count (0..16); led[13] = pause; led[14] = transmitter busy; led[15] = overflow.

Reset
REQ-026 btnC low SHALL immediately force Tx=1, led=0, FIFO empty, pause=0, overflow=0, receiver/transmitter idle, debouncer outputs 0.
REQ-027 Reset mid-frame SHALL abort the frame; after release, Tx stays 1 until a new pop.

Configuration
REQ-028 Macro RISCV_TOP_BTNR_INJECT_EN defined: REQ-022/REQ-023 active; undefined: btnR ignored, no inject logic.

Structure
REQ-029 Package riscv_top_pkg SHALL hold FIFO depth 16, inject byte 0x52, SIM divisor 4, SIM debounce 4, debounce 2^20.
REQ-030 Sub-module riscv_top_debounce SHALL be instantiated twice (btnL, btnR).

Verification (SIM=1)
REQ-031 Reset low then high, no stimulus -> Tx=1, led=0x0000 for 1000 cycles.
REQ-032 Drive 0xA5 on Rx -> led[7:0]=0xA5, same 0xA5 frame appears on Tx, 40 cycles long.
REQ-033 Rx low for 1 cycle only -> false start, no FIFO write, Tx stays 1.
REQ-034 Press btnL, send 17 bytes -> led[13]=1, count 16, led[15]=1; press btnL again -> 16 bytes on Tx.
REQ-035 Press btnR 10 cycles (macro defined) -> 0x52 on Tx; undefined -> Tx idle.
REQ-036 Pull btnC low mid-frame -> Tx=1 and led=0 in that cycle.

Source files
------------

// File: rtl/riscv_top_pkg.sv
// riscv_top_pkg: shared constants, state encodings and the bit-period helper
// for the riscv_top UART echo block.
package riscv_top_pkg;

   localparam int         FIFO_DEPTH      = 16;
   localparam int         FIFO_AW         = 4;
   localparam logic [7:0] INJECT_BYTE     = 8'h52;
   localparam int         SIM_DIV         = 4;
   localparam int         SIM_DEBOUNCE    = 4;
   localparam int         DEBOUNCE_CYCLES = 1 << 20;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   function automatic int bitPeriod(input int sim, input int clkHz, input int baud);
      return (sim != 0) ? SIM_DIV : clkHz / baud;
   endfunction

endpackage

// File: rtl/riscv_top_debounce.sv
// riscv_top_debounce: synchronises a raw push-button and only follows it once
// the synchronised level has differed from the output for STABLE_CYCLES cycles.
module riscv_top_debounce #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   output logic level_o
);

   localparam int            CW   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

   logic          rawMeta_q;
   logic          rawSync_q;
   logic          level_q;
   logic [CW-1:0] stableCnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rawMeta_q   <= 1'b0;
         rawSync_q   <= 1'b0;
         level_q     <= 1'b0;
         stableCnt_q <= '0;
      end else begin
         rawMeta_q <= raw_i;
         rawSync_q <= rawMeta_q;
         // Any bounce back to the current level restarts the stability window.
         if (rawSync_q == level_q) begin
            stableCnt_q <= '0;
         end else if (stableCnt_q == LAST) begin
            level_q     <= rawSync_q;
            stableCnt_q <= '0;
         end else begin
            stableCnt_q <= stableCnt_q + 1'b1;
         end
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/riscv_top.sv
// riscv_top: 8N1 UART receiver feeding a 16-entry FIFO drained by a transmitter,
// with pause/inject buttons and status lamps. Define RISCV_TOP_BTNR_INJECT_EN to enable btnR inject.
module riscv_top
   import riscv_top_pkg::*;
#(
   parameter int SIM    = 0,
   parameter int CLK_HZ = 100000000,
   parameter int BAUD   = 115200
) (
   input  logic        EXCLK,
   input  logic        btnC,
   input  logic        btnL,
   input  logic        btnR,
   input  logic        Rx,
   output logic        Tx,
   output logic [15:0] led
);

   localparam int          DIV       = bitPeriod(SIM, CLK_HZ, BAUD);
   localparam int          DEB       = (SIM != 0) ? SIM_DEBOUNCE : DEBOUNCE_CYCLES;
   localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
   localparam logic [15:0] HALF_LAST = 16'(DIV / 2 - 1);

   logic btnLLevel;
   logic btnRLevel;
   logic btnLPrev_q;
   logic pause_q;

   logic        rxMeta_q;
   logic        rxSync_q;
   logic        rxPrev_q;
   rx_state_e   rxState_q;
   logic [15:0] rxCnt_q;
   logic [2:0]  rxBit_q;
   logic [7:0]  rxShift_q;
   logic        rxValid_q;
   logic [7:0]  rxByte_q;
   logic [7:0]  lastByte_q;

   logic [7:0]         fifoMem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wrPtr_q;
   logic [FIFO_AW-1:0] rdPtr_q;
   logic [4:0]         fifoCount_q;
   logic [4:0]         fifoCount_d;
   logic               overflow_q;
   logic               fifoFull;
   logic               fifoEmpty;
   logic               push;
   logic               pushOk;
   logic               pop;
   logic [7:0]         pushData;

   tx_state_e   txState_q;
   logic [15:0] txCnt_q;
   logic [2:0]  txBit_q;
   logic [7:0]  txShift_q;
   logic        txLine_q;
   logic        txBusy;

   riscv_top_debounce #(.STABLE_CYCLES(DEB)) uDebounceL (
      .clk_i   (EXCLK),
      .rst_ni  (btnC),
      .raw_i   (btnL),
      .level_o (btnLLevel)
   );

   riscv_top_debounce #(.STABLE_CYCLES(DEB)) uDebounceR (
      .clk_i   (EXCLK),
      .rst_ni  (btnC),
      .raw_i   (btnR),
      .level_o (btnRLevel)
   );

   always_ff @(posedge EXCLK or negedge btnC) begin
      if (!btnC) begin
         btnLPrev_q <= 1'b0;
         pause_q    <= 1'b0;
      end else begin
         btnLPrev_q <= btnLLevel;
         if (btnLLevel && !btnLPrev_q) begin
            pause_q <= ~pause_q;
         end
      end
   end

   // Start is confirmed at half a bit; every later sample lands on a bit centre.
   always_ff @(posedge EXCLK or negedge btnC) begin
      if (!btnC) begin
         rxMeta_q   <= 1'b1;
         rxSync_q   <= 1'b1;
         rxPrev_q   <= 1'b1;
         rxState_q  <= RX_IDLE;
         rxCnt_q    <= '0;
         rxBit_q    <= '0;
         rxShift_q  <= '0;
         rxValid_q  <= 1'b0;
         rxByte_q   <= '0;
         lastByte_q <= '0;
      end else begin
         rxMeta_q  <= Rx;
         rxSync_q  <= rxMeta_q;
         rxPrev_q  <= rxSync_q;
         rxValid_q <= 1'b0;
         if (rxValid_q) begin
            lastByte_q <= rxByte_q;
         end
         case (rxState_q)
            RX_IDLE: begin
               if (rxPrev_q && !rxSync_q) begin
                  rxState_q <= RX_START;
                  rxCnt_q   <= '0;
               end
            end
            RX_START: begin
               if (rxCnt_q == HALF_LAST) begin
                  rxCnt_q   <= '0;
                  rxBit_q   <= '0;
                  rxState_q <= rxSync_q ? RX_IDLE : RX_DATA;
               end else begin
                  rxCnt_q <= rxCnt_q + 16'd1;
               end
            end
            RX_DATA: begin
               if (rxCnt_q == DIV_LAST) begin
                  rxCnt_q   <= '0;
                  rxShift_q <= {rxSync_q, rxShift_q[7:1]};
                  rxBit_q   <= rxBit_q + 3'd1;
                  if (rxBit_q == 3'd7) begin
                     rxState_q <= RX_STOP;
                  end
               end else begin
                  rxCnt_q <= rxCnt_q + 16'd1;
               end
            end
            RX_STOP: begin
               if (rxCnt_q == DIV_LAST) begin
                  rxCnt_q   <= '0;
                  rxState_q <= RX_IDLE;
                  if (rxSync_q) begin
                     rxValid_q <= 1'b1;
                     rxByte_q  <= rxShift_q;
                  end
               end else begin
                  rxCnt_q <= rxCnt_q + 16'd1;
               end
            end
            default: rxState_q <= RX_IDLE;
         endcase
      end
   end

`ifdef RISCV_TOP_BTNR_INJECT_EN
   logic btnRPrev_q;
   logic injectPending_q;
   logic injectReq;

   // A received byte wins the write port; an inject waits one cycle behind it.
   assign injectReq = (btnRLevel && !btnRPrev_q) || injectPending_q;
   assign push      = rxValid_q || injectReq;
   assign pushData  = rxValid_q ? rxByte_q : INJECT_BYTE;

   always_ff @(posedge EXCLK or negedge btnC) begin
      if (!btnC) begin
         btnRPrev_q      <= 1'b0;
         injectPending_q <= 1'b0;
      end else begin
         btnRPrev_q      <= btnRLevel;
         injectPending_q <= rxValid_q && injectReq;
      end
   end
`else
   logic unusedBtnR;

   assign unusedBtnR = btnRLevel;
   assign push       = rxValid_q;
   assign pushData   = rxByte_q;
`endif

   assign fifoEmpty = (fifoCount_q == 5'd0);
   assign fifoFull  = (fifoCount_q == 5'(FIFO_DEPTH));
   assign pop       = (txState_q == TX_IDLE) && !pause_q && !fifoEmpty;
   assign pushOk    = push && (!fifoFull || pop);

   always_comb begin
      fifoCount_d = fifoCount_q;
      if (pushOk && !pop) begin
         fifoCount_d = fifoCount_q + 5'd1;
      end else if (!pushOk && pop) begin
         fifoCount_d = fifoCount_q - 5'd1;
      end
   end

   always_ff @(posedge EXCLK) begin
      if (pushOk) begin
         fifoMem[wrPtr_q] <= pushData;
      end
   end

   always_ff @(posedge EXCLK or negedge btnC) begin
      if (!btnC) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         fifoCount_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         fifoCount_q <= fifoCount_d;
         if (pushOk) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         if (push && !pushOk) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // The line register drives Tx directly, so each bit lasts exactly DIV cycles.
   always_ff @(posedge EXCLK or negedge btnC) begin
      if (!btnC) begin
         txState_q <= TX_IDLE;
         txCnt_q   <= '0;
         txBit_q   <= '0;
         txShift_q <= '0;
         txLine_q  <= 1'b1;
      end else begin
         case (txState_q)
            TX_IDLE: begin
               if (pop) begin
                  txShift_q <= fifoMem[rdPtr_q];
                  txLine_q  <= 1'b0;
                  txCnt_q   <= '0;
                  txState_q <= TX_START;
               end
            end
            TX_START: begin
               if (txCnt_q == DIV_LAST) begin
                  txCnt_q   <= '0;
                  txBit_q   <= '0;
                  txLine_q  <= txShift_q[0];
                  txShift_q <= txShift_q >> 1;
                  txState_q <= TX_DATA;
               end else begin
                  txCnt_q <= txCnt_q + 16'd1;
               end
            end
            TX_DATA: begin
               if (txCnt_q == DIV_LAST) begin
                  txCnt_q <= '0;
                  if (txBit_q == 3'd7) begin
                     txLine_q  <= 1'b1;
                     txState_q <= TX_STOP;
                  end else begin
                     txLine_q  <= txShift_q[0];
                     txShift_q <= txShift_q >> 1;
                     txBit_q   <= txBit_q + 3'd1;
                  end
               end else begin
                  txCnt_q <= txCnt_q + 16'd1;
               end
            end
            TX_STOP: begin
               if (txCnt_q == DIV_LAST) begin
                  txCnt_q   <= '0;
                  txState_q <= TX_IDLE;
               end else begin
                  txCnt_q <= txCnt_q + 16'd1;
               end
            end
            default: txState_q <= TX_IDLE;
         endcase
      end
   end

   assign txBusy = (txState_q != TX_IDLE);
   assign Tx     = txLine_q;
   assign led    = {overflow_q, txBusy, pause_q, fifoCount_q, lastByte_q};

endmodule

// File: tb/tb_riscv_top.sv
// tb_riscv_top: directed bench for riscv_top at SIM timing; Tx frames are decoded
// by a monitor and compared against a scoreboard of expected bytes.
`timescale 1ns/1ps
module tb_riscv_top;

   typedef struct {
      logic [7:0] data;
      logic       ok;
   } txFrame_t;

   logic        EXCLK = 1'b0;
   logic        btnC;
   logic        btnL;
   logic        btnR;
   logic        Rx;
   logic        Tx;
   logic [15:0] led;

   int         total = 0;
   int         bad = 0;
   logic       monitorOn = 1'b0;
   logic [7:0] expQ[$];
   txFrame_t   txSeenQ[$];

   riscv_top #(.SIM(1), .CLK_HZ(100000000), .BAUD(115200)) dut (
      .EXCLK (EXCLK),
      .btnC  (btnC),
      .btnL  (btnL),
      .btnR  (btnR),
      .Rx    (Rx),
      .Tx    (Tx),
      .led   (led)
   );

   always #5 EXCLK = ~EXCLK;

   // Decode every Tx frame: all four samples of each bit must agree, start low, stop high.
   initial begin : txMonitor
      logic [39:0] bits;
      txFrame_t    f;
      forever begin
         @(negedge EXCLK);
         if (monitorOn && btnC === 1'b1 && Tx === 1'b0) begin
            bits = '0;
            for (int c = 1; c < 40; c++) begin
               @(negedge EXCLK);
               bits[c] = Tx;
            end
            f.ok = 1'b1;
            for (int b = 0; b < 10; b++) begin
               for (int k = 1; k < 4; k++) begin
                  if (bits[4*b+k] !== bits[4*b]) f.ok = 1'b0;
               end
            end
            if (bits[36] !== 1'b1) f.ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
               f.data[i] = bits[4*(i+1)];
            end
            txSeenQ.push_back(f);
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge EXCLK);
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
      @(negedge EXCLK);
      Rx = 1'b0;
      waitCycles(4);
      for (int i = 0; i < 8; i++) begin
         Rx = data[i];
         waitCycles(4);
      end
      Rx = stopBit;
      waitCycles(4);
      Rx = 1'b1;
      waitCycles(8);
   endtask

   task automatic pressButton(input logic useRight);
      @(negedge EXCLK);
      if (useRight) btnR = 1'b1;
      else btnL = 1'b1;
      waitCycles(10);
      btnL = 1'b0;
      btnR = 1'b0;
      waitCycles(12);
   endtask

   task automatic checkTxFrames(input int n, input int budget);
      int         waited;
      txFrame_t   f;
      logic [7:0] want;
      waited = 0;
      while (txSeenQ.size() < n && waited < budget) begin
         @(negedge EXCLK);
         waited++;
      end
      checkOutput("txFrameArrived", 32'(txSeenQ.size() >= n), 32'd1);
      for (int i = 0; i < n; i++) begin
         if (txSeenQ.size() == 0 || expQ.size() == 0) break;
         f    = txSeenQ.pop_front();
         want = expQ.pop_front();
         checkOutput("txData", 32'(f.data), 32'(want));
         checkOutput("txFrameShape", 32'(f.ok), 32'd1);
      end
   endtask

   initial begin
      int         deviations;
      logic [7:0] b;
      btnC = 1'b1;
      btnL = 1'b0;
      btnR = 1'b0;
      Rx   = 1'b1;
      waitCycles(2);

      btnC = 1'b0;
      #1;
      checkOutput("resetTx", 32'(Tx), 32'd1);
      checkOutput("resetLed", 32'(led), 32'h0);
      waitCycles(4);
      btnC = 1'b1;
      monitorOn = 1'b1;
      deviations = 0;
      repeat (1000) begin
         @(negedge EXCLK);
         if (Tx !== 1'b1 || led !== 16'h0) deviations++;
      end
      checkOutput("idleAfterReset", 32'(deviations), 32'd0);

      expQ.push_back(8'hA5);
      applyStimulus(8'hA5, 1'b1);
      checkOutput("rxLedByte", 32'(led[7:0]), 32'hA5);
      checkOutput("txBusyLed", 32'(led[14]), 32'd1);
      checkOutput("countAfterPop", 32'(led[12:8]), 32'd0);
      checkTxFrames(1, 200);

      @(negedge EXCLK);
      Rx = 1'b0;
      @(negedge EXCLK);
      Rx = 1'b1;
      waitCycles(60);
      checkOutput("falseStartCount", 32'(led[12:8]), 32'd0);
      checkOutput("falseStartLed", 32'(led[7:0]), 32'hA5);
      checkOutput("falseStartNoTx", 32'(txSeenQ.size()), 32'd0);
      checkOutput("falseStartTxHigh", 32'(Tx), 32'd1);

      applyStimulus(8'h3C, 1'b0);
      waitCycles(60);
      checkOutput("framingCount", 32'(led[12:8]), 32'd0);
      checkOutput("framingLed", 32'(led[7:0]), 32'hA5);
      checkOutput("framingNoTx", 32'(txSeenQ.size()), 32'd0);

      pressButton(1'b0);
      checkOutput("pauseOn", 32'(led[13]), 32'd1);
      for (int i = 0; i < 17; i++) begin
         b = 8'(i * 37 + 3);
         if (i < 16) expQ.push_back(b);
         applyStimulus(b, 1'b1);
      end
      checkOutput("pausedCount", 32'(led[12:8]), 32'd16);
      checkOutput("overflowFlag", 32'(led[15]), 32'd1);
      checkOutput("pausedNoTx", 32'(txSeenQ.size()), 32'd0);
      checkOutput("pausedTxHigh", 32'(Tx), 32'd1);
      pressButton(1'b0);
      checkOutput("pauseOff", 32'(led[13]), 32'd0);
      checkTxFrames(16, 1200);
      checkOutput("overflowSticky", 32'(led[15]), 32'd1);
      checkOutput("drainedCount", 32'(led[12:8]), 32'd0);

`ifdef RISCV_TOP_BTNR_INJECT_EN
      expQ.push_back(8'h52);
      pressButton(1'b1);
      checkTxFrames(1, 200);
`else
      pressButton(1'b1);
      waitCycles(200);
      checkOutput("injectIgnoredNoTx", 32'(txSeenQ.size()), 32'd0);
      checkOutput("injectIgnoredCount", 32'(led[12:8]), 32'd0);
`endif

      applyStimulus(8'h3C, 1'b1);
      waitCycles(10);
      checkOutput("midFrameBusy", 32'(led[14]), 32'd1);
      btnC = 1'b0;
      #1;
      checkOutput("midResetTx", 32'(Tx), 32'd1);
      checkOutput("midResetLed", 32'(led), 32'h0);
      waitCycles(3);
      btnC = 1'b1;
      deviations = 0;
      repeat (100) begin
         @(negedge EXCLK);
         if (Tx !== 1'b1) deviations++;
      end
      checkOutput("postResetTxIdle", 32'(deviations), 32'd0);
      checkOutput("postResetLed", 32'(led), 32'h0);
      txSeenQ.delete();

      checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
